// File: rtl/sram_write_buffer.sv
// Renderer write queue in front of the SRAM controller's renderer port.
// A FIFO of {addr, data}; an optional mode merges a push into the newest entry when the addresses match.
`ifndef SRAM_ADDRESS_WIDTH
`define SRAM_ADDRESS_WIDTH 16
`endif
`ifndef SRAM_DATA_WIDTH
`define SRAM_DATA_WIDTH 16
`endif

package sram_pkg;
   localparam int SRAM_ADDR_W = `SRAM_ADDRESS_WIDTH;
   localparam int SRAM_DATA_W = `SRAM_DATA_WIDTH;

   typedef struct packed {
      logic [SRAM_ADDR_W-1:0] address;
      logic                   oe_n;
      logic                   we_n;
      logic                   den;
      logic [SRAM_DATA_W-1:0] dout;
   } SramRequest_t;

   typedef struct packed {
      logic [SRAM_DATA_W-1:0] din;
      logic                   done;
   } SramResult_t;
endpackage

module sram_write_buffer
   import sram_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int COALESCE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [SRAM_ADDR_W-1:0]   wr_addr,
   input  logic [SRAM_DATA_W-1:0]   wr_data,
   output SramRequest_t             sramRequest,
   input  SramResult_t              sramResult,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     coalesced
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, newest, mem_idx;
   logic [CW-1:0] count_q, count_d;
   logic          coalesced_q, coalesced_d;
   logic          full, push, pop, coal_hit, enq, mem_we;

   logic [SRAM_ADDR_W-1:0] mem_addr [DEPTH];
   logic [SRAM_DATA_W-1:0] mem_data [DEPTH];

   logic unused_din;
   assign unused_din = ^sramResult.din;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign wr_ready = !full;
   assign count    = count_q;
   assign coalesced = coalesced_q;
   assign newest   = tail_q - PW'(1);

   always_comb begin
      push = wr_valid && !full;
      pop  = !empty && sramResult.done;
      // The newest entry is only safe to overwrite if it is not the head being retired right now.
      coal_hit = (COALESCE != 0) && push && !empty && (mem_addr[newest] == wr_addr)
                 && ((count_q >= CW'(2)) || !sramResult.done);
      enq  = push && !coal_hit;

      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      coalesced_d = coal_hit;
      mem_we      = push;
      mem_idx     = coal_hit ? newest : tail_q;

      if (enq) tail_d = tail_q + PW'(1);
      if (pop) head_d = head_q + PW'(1);
      case ({enq, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         coalesced_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         coalesced_q <= coalesced_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_addr[mem_idx] <= wr_addr;
         mem_data[mem_idx] <= wr_data;
      end
   end

   always_comb begin
      sramRequest         = '0;
      sramRequest.oe_n    = 1'b1;
      sramRequest.we_n    = 1'b1;
      if (!empty) begin
         sramRequest.address = mem_addr[head_q];
         sramRequest.dout    = mem_data[head_q];
         sramRequest.we_n    = 1'b0;
         sramRequest.den     = 1'b1;
      end
   end
endmodule

// File: tb/tb_sram_write_buffer.sv
// Bench for sram_write_buffer: hand vectors for the corner cases plus random traffic against a queue model.
module tb_sram_write_buffer;
   import sram_pkg::*;

   localparam int DEPTH = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   wr_valid = 1'b0;
   logic                   wr_ready;
   logic [SRAM_ADDR_W-1:0] wr_addr = '0;
   logic [SRAM_DATA_W-1:0] wr_data = '0;
   SramRequest_t           sramRequest;
   SramResult_t            sramResult;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   coalesced;

   sram_write_buffer #(.DEPTH(DEPTH), .COALESCE(1)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .sramRequest(sramRequest),
      .sramResult(sramResult), .count(count), .empty(empty), .coalesced(coalesced)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } ent_t;

   ent_t q[$];
   logic exp_coal = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the queue model.
   task automatic chk_model(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".ready"}, 32'(wr_ready), 32'(q.size() < DEPTH));
      chk({tag, ".coal"}, 32'(coalesced), 32'(exp_coal));
      chk({tag, ".we_n"}, 32'(sramRequest.we_n), 32'(q.size() == 0));
      chk({tag, ".oe_n"}, 32'(sramRequest.oe_n), 32'd1);
      chk({tag, ".den"}, 32'(sramRequest.den), 32'(q.size() != 0));
      chk({tag, ".addr"}, 32'(sramRequest.address), q.size() != 0 ? 32'(q[0].addr) : 32'd0);
      chk({tag, ".dout"}, 32'(sramRequest.dout), q.size() != 0 ? 32'(q[0].data) : 32'd0);
   endtask

   // One clock: drive inputs, advance the model by the behavioural rules, compare after the edge.
   task automatic step(input string tag, input logic v, input logic [15:0] a,
                       input logic [15:0] d, input logic dn);
      logic push, pop, hit;
      ent_t e;
      @(negedge clk);
      wr_valid = v; wr_addr = a; wr_data = d;
      sramResult.done = dn; sramResult.din = 16'hDEAD;
      push = v && (q.size() < DEPTH);
      pop  = (q.size() != 0) && dn;
      hit  = push && (q.size() != 0) && (q[$].addr == a) && !(q.size() == 1 && dn);
      if (hit) q[$].data = d;
      if (pop) void'(q.pop_front());
      if (push && !hit) begin
         e.addr = a; e.data = d;
         q.push_back(e);
      end
      exp_coal = hit;
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_valid = 1'b0;
      sramResult = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      exp_coal = 1'b0;
      #1;
      chk_model("reset");
   endtask

   typedef struct {
      logic        v;
      logic [15:0] a;
      logic [15:0] d;
      logic        dn;
      int          cnt;
      logic        coal;
      logic        we_n;
      logic [15:0] ra;
      logic [15:0] rd;
   } vec_t;

   function automatic vec_t mk(logic v, logic [15:0] a, logic [15:0] d, logic dn,
                               int cnt, logic coal, logic we_n, logic [15:0] ra, logic [15:0] rd);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.dn = dn; r.cnt = cnt;
      r.coal = coal; r.we_n = we_n; r.ra = ra; r.rd = rd;
      return r;
   endfunction

   vec_t vecs[12];

   initial begin
      sramResult = '0;
      // Single write, coalesce of the newest entry, and the no-coalesce-while-issuing case.
      vecs[0]  = mk(1, 16'h0010, 16'h1234, 0, 1, 0, 0, 16'h0010, 16'h1234);
      vecs[1]  = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000);
      vecs[2]  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000);
      vecs[3]  = mk(1, 16'h0020, 16'hAAAA, 0, 1, 0, 0, 16'h0020, 16'hAAAA);
      vecs[4]  = mk(1, 16'h0021, 16'hBBBB, 0, 2, 0, 0, 16'h0020, 16'hAAAA);
      vecs[5]  = mk(1, 16'h0021, 16'hCCCC, 0, 2, 1, 0, 16'h0020, 16'hAAAA);
      vecs[6]  = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0021, 16'hCCCC);
      vecs[7]  = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0021, 16'hCCCC);
      vecs[8]  = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000);
      vecs[9]  = mk(1, 16'h0030, 16'h1111, 0, 1, 0, 0, 16'h0030, 16'h1111);
      vecs[10] = mk(1, 16'h0030, 16'h5555, 1, 1, 0, 0, 16'h0030, 16'h5555);
      vecs[11] = mk(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000);

      do_reset();
      chk("reset.coal_raw", 32'(coalesced), 32'd0);
      chk("reset.ready_raw", 32'(wr_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         step("vec", vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].dn);
         chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d.coal", i), 32'(coalesced), 32'(vecs[i].coal));
         chk($sformatf("vec%0d.we_n", i), 32'(sramRequest.we_n), 32'(vecs[i].we_n));
         chk($sformatf("vec%0d.addr", i), 32'(sramRequest.address), 32'(vecs[i].ra));
         chk($sformatf("vec%0d.dout", i), 32'(sramRequest.dout), 32'(vecs[i].rd));
      end

      // Fill to full, try a matching push while full, then drain in order.
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         step("fill", 1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 0);
      chk("full.count", 32'(count), 32'd8);
      chk("full.ready", 32'(wr_ready), 32'd0);
      step("full_push", 1, 16'h0107, 16'hFFFF, 0);
      chk("full.no_coal", 32'(coalesced), 32'd0);
      step("first_pop", 0, 16'h0, 16'h0, 1);
      chk("first_pop.ready", 32'(wr_ready), 32'd1);
      chk("first_pop.head", 32'(sramRequest.address), 32'h0101);
      for (int i = 0; i < 16; i++)
         step("drain", 0, 16'h0, 16'h0, 1'(i % 2));
      chk("drain.empty", 32'(empty), 32'd1);

      // Random traffic on a small address set so coalescing and wrap both occur.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic v, dn;
         v  = ($urandom_range(0, 3) != 0);
         dn = (i % 2 == 1) && ((i % 80) >= 24) && ($urandom_range(0, 4) != 0);
         step("rand", v, 16'h0040 + 16'($urandom_range(0, 3)), 16'($urandom), dn);
      end

      // Asynchronous reset with five entries pending.
      do_reset();
      for (int i = 0; i < 5; i++)
         step("pre_rst", 1, 16'h0200 + 16'(i), 16'hB000 + 16'(i), 0);
      chk("pre_rst.count", 32'(count), 32'd5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst.empty", 32'(empty), 32'd1);
      chk("async_rst.we_n", 32'(sramRequest.we_n), 32'd1);
      chk("async_rst.den", 32'(sramRequest.den), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      exp_coal = 1'b0;
      for (int i = 0; i < 4; i++)
         step("post_rst", 0, 16'h0, 16'h0, 1);
      step("post_rst_push", 1, 16'h0300, 16'hC0DE, 0);
      step("post_rst_pop", 0, 16'h0, 16'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_write_buffer.md
Name: sram_write_buffer

Overview:
- Renderer-side write queue that feeds the renderer port of the SRAM arbiter/controller.
- Accepts character-cell write commands from the renderer with a valid/ready handshake and buffers them in a FIFO.
- Presents the oldest entry as an SramRequest_t write, and retires it when the controller grants the renderer slot (result done).
- Optional write-coalescing merges back-to-back writes to the same address, which reduces SRAM slot usage during scroll and clear bursts.

Parameters:
DEPTH, 8, FIFO entries; power of two, ≥2
COALESCE, 1, 1 = merge a push into the newest queued entry on address match; 0 = plain FIFO

Ports:
clk  input  1  25 MHz system clock, same as the SRAM controller
rst  input  1  reset
wr_valid  input  1  renderer has a write command
wr_ready  output  1  buffer can accept a command
wr_addr  input  `SRAM_ADDRESS_WIDTH  target SRAM word address
wr_data  input  `SRAM_DATA_WIDTH  data word
sramRequest  output  SramRequest_t  request to the controller's renderer port (address, oe_n, we_n, den, dout)
sramResult  input  SramResult_t  result from the controller's renderer port; only .done is used
count  output  $clog2(DEPTH)+1  entries currently queued
empty  output  1  count == 0
coalesced  output  1  one-cycle pulse when a push merged into an existing entry

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - Head pointer, tail pointer and count clear to 0, so empty=1 and wr_ready=1.
  - coalesced=0.
  - sramRequest is idle: we_n=1, oe_n=1, den=0, address=0, dout=0.
  - Storage array is not cleared.
  - Reset mid-burst discards all pending entries; no partial write is issued after rst deasserts.
- Storage: circular buffer of {addr, data}, DEPTH entries; head = oldest, tail = next free slot.
- wr_ready = !full, where full = (count == DEPTH). Registered-state only; no combinational path from wr_valid or wr_addr.
- Push = wr_valid && wr_ready.
- Request generation (combinational from head state):
  - When !empty: address = head.addr, dout = head.data, we_n=0, oe_n=1, den=1.
  - When empty: idle values as at reset.
- Pop = !empty && sramResult.done.
  - done is asserted in the same cycle the controller drives the renderer slot, so the head write completes in that cycle.
  - Head advances on the next clk edge.
  - The request holds steady across the intervening VGA slot cycles.
- Coalesce hit (COALESCE=1 only): push && wr_addr == newest.addr && the newest entry is not being issued in this cycle. This means one of:
  - count ≥ 2, or
  - count == 1 && !sramResult.done.
- On a coalesce hit:
  - Overwrite newest.data with wr_data.
  - Tail and count are unchanged, apart from any concurrent pop.
  - coalesced pulses 1 in the following cycle.
- If count == 1 and the head is being popped in that cycle, an equal-address push is not coalesced; it is enqueued as a new entry.
- Count update:
  - +1 on a non-coalesced push without pop.
  - −1 on pop without a non-coalesced push.
  - Unchanged otherwise, including a simultaneous push and pop.
- Pointers wrap modulo DEPTH.
- Full: wr_ready=0, even if the incoming address would coalesce. A pop in a full cycle frees a slot, and wr_ready rises the next cycle.
- Empty with a push and done in the same cycle: no pop (entry not yet visible). The entry is presented from the next cycle.
- Ordering: writes reach SRAM in push order; coalescing only replaces data in the newest entry.
- Throughput: ≤1 retire per 2 clk, set by the controller's alternating slots. Sustained 1 push/clk fills the FIFO unless pushes coalesce.

Test Plan:
1. After rst, push A=0x0010/D=0x1234 with done asserted every other cycle -> request shows we_n=0, den=1, address=0x0010, dout=0x1234 from the cycle after the push; pop at the first done; empty=1 after; count sequence 0→1→0.
2. Push 8 distinct addresses back-to-back (DEPTH=8) with done held 0 -> count=8, wr_ready=0; enable alternating done -> retired in push order, wr_ready=1 the cycle after the first pop.
3. Push 0x0020/0xAAAA, 0x0021/0xBBBB, 0x0021/0xCCCC with no done -> coalesced pulse once, count=2; SRAM sees 0x0021 written with 0xCCCC only.
4. count=1 (addr 0x0030), push 0x0030/0x5555 in the cycle done=1 -> no coalesce, count remains 1, next request is 0x0030/0x5555.
5. Wrap: 20 pushes interleaved with done so pointers wrap twice -> data order intact, count never exceeds 8.
6. Assert rst while count=5 -> next cycle: empty=1, we_n=1, den=0; no further writes after release until a new push.
